// File: rtl/gb_host.sv
// Ghostbus root initiator: turns command, write-data and read-response streams into registered
// gb_addr/gb_dout/gb_we cycles, sampling gb_din a fixed RD_LAT edges after each read address.
module gb_host #(
    parameter int unsigned AW     = 12,
    parameter int unsigned DW     = 32,
    parameter int unsigned LW     = 8,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          gb_clk,
    input  logic          gb_rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    input  logic [DW-1:0] gb_din,
    output logic          gb_we
);

    // Wait counter loads RD_LAT-1; keep at least one bit so RD_LAT=1 still elaborates.
    localparam int unsigned WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WCW-1:0] WaitInit = WCW'(RD_LAT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRdWait,
        StRdResp
    } state_e;

    state_e state_q, state_d;

    logic [AW-1:0]  cur_addr_q, cur_addr_d;
    logic [LW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [AW-1:0]  gb_addr_q, gb_addr_d;
    logic [DW-1:0]  gb_dout_q, gb_dout_d;
    logic           gb_we_q, gb_we_d;
    logic           rd_valid_q, rd_valid_d;
    logic [DW-1:0]  rd_data_q, rd_data_d;

    logic cmd_fire;
    logic wr_fire;
    logic rd_fire;
    logic last_beat;

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign wr_fire   = wr_valid & wr_ready;
    assign rd_fire   = rd_valid_q & rd_ready;
    assign last_beat = (beat_cnt_q == '0);

    // State register
    always_ff @(posedge gb_clk or negedge gb_rstn) begin
        if (!gb_rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    state_d = cmd_we ? StWrite : StRdWait;
                end
            end
            StWrite: begin
                if (wr_fire && last_beat) begin
                    state_d = StIdle;
                end
            end
            StRdWait: begin
                if (wait_cnt_q == '0) begin
                    state_d = StRdResp;
                end
            end
            StRdResp: begin
                if (rd_fire) begin
                    state_d = last_beat ? StIdle : StRdWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic decoded from state
    always_comb begin
        cmd_ready = (state_q == StIdle);
        wr_ready  = (state_q == StWrite);
        busy      = (state_q != StIdle);
    end

    // Datapath next-state
    always_comb begin
        cur_addr_d = cur_addr_q;
        beat_cnt_d = beat_cnt_q;
        wait_cnt_d = wait_cnt_q;
        gb_addr_d  = gb_addr_q;
        gb_dout_d  = gb_dout_q;
        gb_we_d    = 1'b0;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    cur_addr_d = cmd_addr;
                    beat_cnt_d = cmd_len;
                    // Reads put the address on the bus immediately to start the latency window.
                    if (!cmd_we) begin
                        gb_addr_d  = cmd_addr;
                        wait_cnt_d = WaitInit;
                    end
                end
            end
            StWrite: begin
                if (wr_fire) begin
                    gb_addr_d  = cur_addr_q;
                    gb_dout_d  = wr_data;
                    gb_we_d    = 1'b1;
                    cur_addr_d = cur_addr_q + AW'(1);
                    beat_cnt_d = beat_cnt_q - LW'(1);
                end
            end
            StRdWait: begin
                wait_cnt_d = wait_cnt_q - WCW'(1);
                if (wait_cnt_q == '0) begin
                    rd_data_d  = gb_din;
                    rd_valid_d = 1'b1;
                end
            end
            StRdResp: begin
                if (rd_fire) begin
                    rd_valid_d = 1'b0;
                    if (!last_beat) begin
                        cur_addr_d = cur_addr_q + AW'(1);
                        gb_addr_d  = cur_addr_q + AW'(1);
                        beat_cnt_d = beat_cnt_q - LW'(1);
                        wait_cnt_d = WaitInit;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset drops any in-flight beat and strobe.
    always_ff @(posedge gb_clk or negedge gb_rstn) begin
        if (!gb_rstn) begin
            cur_addr_q <= '0;
            beat_cnt_q <= '0;
            wait_cnt_q <= '0;
            gb_addr_q  <= '0;
            gb_dout_q  <= '0;
            gb_we_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            cur_addr_q <= cur_addr_d;
            beat_cnt_q <= beat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            gb_addr_q  <= gb_addr_d;
            gb_dout_q  <= gb_dout_d;
            gb_we_q    <= gb_we_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign gb_addr  = gb_addr_q;
    assign gb_dout  = gb_dout_q;
    assign gb_we    = gb_we_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_gb_host.sv
// Self-checking bench for gb_host: vector table, hand-written corner sequences and random bursts
// checked against a transaction-level model (expected bus beats kept in queues).
module tb_gb_host;

    localparam int AW     = 12;
    localparam int DW     = 32;
    localparam int LW     = 8;
    localparam int RD_LAT = 2;

    logic          gb_clk;
    logic          gb_rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_dout;
    logic [DW-1:0] gb_din;
    logic          gb_we;

    gb_host #(
        .AW    (AW),
        .DW    (DW),
        .LW    (LW),
        .RD_LAT(RD_LAT)
    ) dut (
        .gb_clk   (gb_clk),
        .gb_rstn  (gb_rstn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .busy     (busy),
        .gb_addr  (gb_addr),
        .gb_dout  (gb_dout),
        .gb_din   (gb_din),
        .gb_we    (gb_we)
    );

    initial gb_clk = 1'b0;
    always #5 gb_clk = ~gb_clk;

    // Responder: one register stage, so data for an address is on gb_din two edges after it.
    logic [DW-1:0] mem [4096];
    logic [DW-1:0] din_q;
    always @(posedge gb_clk) din_q <= mem[gb_addr];
    assign gb_din = din_q;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int            gap;
        int            stall;
        bit            seq;
        int            exp_beats;
        logic [AW-1:0] exp_last;
    } vec_t;

    beat_t         exp_wr[$];
    beat_t         exp_rd[$];
    int            errors = 0;
    int            checks = 0;
    int            beats_seen = 0;
    logic [AW-1:0] last_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait expired, expected handshake within 100 cycles", name);
    endtask

    // Observes the bus between edges and retires beats against the model queues.
    task automatic monitor();
        beat_t b;
        if (!gb_rstn) return;
        if (gb_we) begin
            beats_seen++;
            last_addr = gb_addr;
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_we: got write at 0x%0h, expected none", gb_addr);
            end else begin
                b = exp_wr.pop_front();
                check("wr_addr", gb_addr, b.a);
                check("wr_data", gb_dout, b.d);
            end
        end
        if (rd_valid && rd_ready) begin
            beats_seen++;
            last_addr = gb_addr;
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_rd: got read beat 0x%0h, expected none", rd_data);
            end else begin
                b = exp_rd.pop_front();
                check("rd_addr", gb_addr, b.a);
                check("rd_data", rd_data, b.d);
            end
        end
    endtask

    task automatic cycle();
        @(negedge gb_clk);
        monitor();
        @(posedge gb_clk);
        #1;
    endtask

    task automatic send_cmd(input bit we, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_len   = l;
        while (!cmd_ready && n < 100) begin
            cycle();
            n++;
        end
        if (!cmd_ready) timeout_fail("cmd_accept");
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic write_beats(input logic [AW-1:0] a, input int nb, input int gap, input bit seq);
        for (int i = 0; i < nb; i++) begin
            beat_t b;
            int    n = 0;
            repeat (gap) cycle();
            b.a = a + AW'(i);
            b.d = seq ? DW'(i + 1) : DW'($urandom);
            exp_wr.push_back(b);
            wr_valid = 1'b1;
            wr_data  = b.d;
            while (!wr_ready && n < 100) begin
                cycle();
                n++;
            end
            if (!wr_ready) timeout_fail("wr_accept");
            cycle();
            wr_valid = 1'b0;
        end
    endtask

    // stall_beat < 0 stalls every beat; otherwise only the given beat index.
    task automatic read_beats(input logic [AW-1:0] a, input int nb, input int stall,
                              input int stall_beat);
        for (int i = 0; i < nb; i++) begin
            beat_t b;
            int    n = 0;
            b.a = a + AW'(i);
            b.d = mem[b.a];
            exp_rd.push_back(b);
            while (!rd_valid && n < 100) begin
                cycle();
                n++;
            end
            if (!rd_valid) timeout_fail("rd_valid");
            if (stall_beat < 0 || stall_beat == i) begin
                for (int k = 0; k < stall; k++) begin
                    check("stall_addr_hold", gb_addr, b.a);
                    check("stall_rd_valid", rd_valid, 1);
                    check("stall_no_we", gb_we, 0);
                    cycle();
                end
            end
            rd_ready = 1'b1;
            cycle();
            rd_ready = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v);
        beats_seen = 0;
        send_cmd(v.we, v.addr, v.len);
        if (v.we) write_beats(v.addr, int'(v.len) + 1, v.gap, v.seq);
        else read_beats(v.addr, int'(v.len) + 1, v.stall, -1);
        cycle();
        check("vec_beats", beats_seen, v.exp_beats);
        check("vec_last_addr", last_addr, v.exp_last);
        check("vec_idle", cmd_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[7];
        vec_t  rv;
        logic [DW-1:0] d;

        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        mem[12'h200] = 32'h1234_5678;

        vecs[0] = '{1'b1, 12'h0A5, 8'd0,   0, 0, 1'b0, 1,   12'h0A5};
        vecs[1] = '{1'b1, 12'hFFE, 8'd3,   1, 0, 1'b1, 4,   12'h001};
        vecs[2] = '{1'b0, 12'hFFF, 8'd1,   0, 1, 1'b0, 2,   12'h000};
        vecs[3] = '{1'b0, 12'h300, 8'd0,   0, 0, 1'b0, 1,   12'h300};
        vecs[4] = '{1'b1, 12'hF80, 8'd255, 0, 0, 1'b0, 256, 12'h07F};
        vecs[5] = '{1'b0, 12'h7F0, 8'd7,   0, 2, 1'b0, 8,   12'h7F7};
        vecs[6] = '{1'b1, 12'h123, 8'd2,   2, 0, 1'b0, 3,   12'h125};

        gb_rstn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        repeat (3) @(posedge gb_clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_gb_we", gb_we, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_gb_addr", gb_addr, 0);
        check("rst_wr_ready", wr_ready, 0);
        gb_rstn = 1'b1;
        cycle();

        // Single write: strobe lands with the data and the host is already idle.
        send_cmd(1'b1, 12'h0A5, 8'd0);
        d = 32'hDEAD_BEEF;
        exp_wr.push_back('{12'h0A5, d});
        wr_valid = 1'b1;
        wr_data  = d;
        cycle();
        wr_valid = 1'b0;
        check("t1_gb_we", gb_we, 1);
        check("t1_gb_addr", gb_addr, 12'h0A5);
        check("t1_gb_dout", gb_dout, 32'hDEAD_BEEF);
        check("t1_idle", cmd_ready, 1);
        check("t1_busy", busy, 0);
        cycle();
        check("t1_we_pulse_end", gb_we, 0);

        // Single read: rd_valid rises exactly RD_LAT edges after acceptance.
        exp_rd.push_back('{12'h200, 32'h1234_5678});
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 12'h200;
        cmd_len   = 8'd0;
        cycle();
        cmd_valid = 1'b0;
        check("t2_gb_addr", gb_addr, 12'h200);
        check("t2_rd_valid_t0", rd_valid, 0);
        cycle();
        check("t2_rd_valid_t1", rd_valid, 0);
        cycle();
        check("t2_rd_valid_t2", rd_valid, 1);
        check("t2_rd_data", rd_data, 32'h1234_5678);
        rd_ready = 1'b1;
        cycle();
        rd_ready = 1'b0;
        check("t2_rd_valid_drop", rd_valid, 0);
        check("t2_idle", cmd_ready, 1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Read burst with a long consumer stall on the middle beat.
        beats_seen = 0;
        send_cmd(1'b0, 12'h010, 8'd2);
        read_beats(12'h010, 3, 5, 1);
        cycle();
        check("t4_beats", beats_seen, 3);
        check("t4_last", last_addr, 12'h012);

        // A command presented mid-burst waits for IDLE.
        beats_seen = 0;
        send_cmd(1'b1, 12'h0C0, 8'd1);
        cmd_we    = 1'b0;
        cmd_addr  = 12'h400;
        cmd_len   = 8'd0;
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("t5_cmd_ready_busy", cmd_ready, 0);
            cycle();
        end
        write_beats(12'h0C0, 2, 0, 1'b0);
        check("t5_ready_after", cmd_ready, 1);
        cycle();
        cmd_valid = 1'b0;
        check("t5_accepted", busy, 1);
        check("t5_rd_addr", gb_addr, 12'h400);
        read_beats(12'h400, 1, 0, -1);
        cycle();
        check("t5_beats", beats_seen, 3);

        // Reset during beat 2 of a 4-beat write aborts the burst.
        send_cmd(1'b1, 12'h100, 8'd3);
        exp_wr.push_back('{12'h100, 32'hA0A0_0001});
        wr_valid = 1'b1;
        wr_data  = 32'hA0A0_0001;
        cycle();
        wr_data  = 32'hA0A0_0002;
        cycle();
        check("t6_beat2_we", gb_we, 1);
        check("t6_beat2_addr", gb_addr, 12'h101);
        #1;
        gb_rstn  = 1'b0;
        wr_valid = 1'b0;
        #1;
        check("t6_rst_we", gb_we, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_cmd_ready", cmd_ready, 1);
        check("t6_rst_wr_ready", wr_ready, 0);
        exp_wr.delete();
        @(posedge gb_clk);
        #1;
        gb_rstn = 1'b1;
        cycle();
        rv = '{1'b1, 12'h222, 8'd1, 0, 0, 1'b0, 2, 12'h223};
        run_vec(rv);

        // Random bursts against the queue model.
        for (int t = 0; t < 40; t++) begin
            rv.we        = 1'($urandom_range(0, 1));
            rv.addr      = AW'($urandom);
            rv.len       = LW'($urandom_range(0, 5));
            rv.gap       = $urandom_range(0, 2);
            rv.stall     = $urandom_range(0, 3);
            rv.seq       = 1'b0;
            rv.exp_beats = int'(rv.len) + 1;
            rv.exp_last  = rv.addr + AW'(rv.len);
            run_vec(rv);
        end

        repeat (3) cycle();
        check("wr_queue_drained", exp_wr.size(), 0);
        check("rd_queue_drained", exp_rd.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
